dual_write_scoreboard_regfile: RTL and testbench

DUAL_WRITE_SCOREBOARD_REGFILE -- requirements
Module: dual_write_scoreboard_regfile

---
 rtl/dual_write_scoreboard_regfile.sv | 102 ++++++++++
 tb/tb_dual_write_scoreboard_regfile.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_write_scoreboard_regfile.sv
// Two-write-port register file with a per-register pending (scoreboard) bit and NUM_RD registered read ports.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes (and the updated pending bit) to reads.
module dual_write_scoreboard_regfile #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [2**ADDR_W-1:0]     busy_vec
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]        rd_src [NUM_RD];
    logic [NUM_RD-1:0]        rd_pend;

    // Port 1 overrides port 0; a busy_set to the same register beats the write's clear.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int n = 0; n < DEPTH; n++) begin
            if (we0 && waddr0 == ADDR_W'(n)) begin
                mem_d[n]  = wdata0;
                busy_d[n] = 1'b0;
            end
            if (we1 && waddr1 == ADDR_W'(n)) begin
                mem_d[n]  = wdata1;
                busy_d[n] = 1'b0;
            end
            if (busy_set && busy_addr == ADDR_W'(n)) begin
                busy_d[n] = 1'b1;
            end
            if (ZERO_REG != 0 && n == 0) begin
                mem_d[n]  = '0;
                busy_d[n] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
`ifdef REGFILE_BYPASS_EN
            rd_src[i]  = mem_d[rd_addr[i*ADDR_W +: ADDR_W]];
            rd_pend[i] = busy_d[rd_addr[i*ADDR_W +: ADDR_W]];
`else
            rd_src[i]  = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
            rd_pend[i] = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
`endif
        end
    end

    // Idle ports keep their last data but drop valid.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_en[i]) begin
                rd_data_d[i*DATA_W +: DATA_W] = rd_src[i];
                rd_valid_d[i]                 = ~rd_pend[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < DEPTH; n++) begin
                mem_q[n] <= '0;
            end
            busy_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_dual_write_scoreboard_regfile.sv
// Bench for dual_write_scoreboard_regfile: two instances (ZERO_REG=0 and ZERO_REG=1) share stimulus and
// are checked against an array-based reference model through expected-value queues.
module tb_dual_write_scoreboard_regfile;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic we0 = 1'b0, we1 = 1'b0, busy_set = 1'b0;
  logic [AW-1:0] waddr0 = '0, waddr1 = '0, busy_addr = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [NR-1:0] rd_en = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data_a, rd_data_z;
  logic [NR-1:0] rd_valid_a, rd_valid_z;
  logic [DEPTH-1:0] busy_vec_a, busy_vec_z;

  int checks = 0;
  int failures = 0;

  // queue entries: index (m*NR+i) selects instance m, port i
  logic [2*NR*DW-1:0] exp_d_q[$];
  logic [2*NR-1:0] exp_v_q[$];
  logic [2*DEPTH-1:0] exp_b_q[$];

  logic [DW-1:0] ref_mem[2][DEPTH];
  logic ref_busy[2][DEPTH];
  logic [DW-1:0] ref_rd[2][NR];

  dual_write_scoreboard_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) u_dut_a (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .busy_vec(busy_vec_a)
  );

  dual_write_scoreboard_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_z), .rd_valid(rd_valid_z), .busy_vec(busy_vec_z)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < DEPTH; a++) begin
        ref_mem[m][a] = '0;
        ref_busy[m][a] = 1'b0;
      end
      for (int i = 0; i < NR; i++) ref_rd[m][i] = '0;
    end
  endtask

  // reference: a register's new content / pending state follows the written-value and set-wins rules
  task automatic model_step();
    logic [2*NR*DW-1:0] ed;
    logic [2*NR-1:0] ev;
    logic [2*DEPTH-1:0] eb;
    logic [DW-1:0] new_mem[DEPTH];
    logic new_busy[DEPTH];
    logic [DW-1:0] v;
    logic b;
    int a;
    ed = '0; ev = '0; eb = '0;
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < DEPTH; n++) begin
        new_mem[n] = ref_mem[m][n];
        new_busy[n] = ref_busy[m][n];
        if (we0 && int'(waddr0) == n) begin new_mem[n] = wdata0; new_busy[n] = 1'b0; end
        if (we1 && int'(waddr1) == n) begin new_mem[n] = wdata1; new_busy[n] = 1'b0; end
        if (busy_set && int'(busy_addr) == n) new_busy[n] = 1'b1;
        if (m == 1 && n == 0) begin new_mem[n] = '0; new_busy[n] = 1'b0; end
      end
      for (int i = 0; i < NR; i++) begin
        a = int'(rd_addr[i*AW +: AW]);
`ifdef REGFILE_BYPASS_EN
        v = new_mem[a];
        b = new_busy[a];
`else
        v = ref_mem[m][a];
        b = ref_busy[m][a];
`endif
        if (rd_en[i]) begin
          ref_rd[m][i] = v;
          ev[m*NR+i] = ~b;
        end
        ed[(m*NR+i)*DW +: DW] = ref_rd[m][i];
      end
      for (int n = 0; n < DEPTH; n++) begin
        ref_mem[m][n] = new_mem[n];
        ref_busy[m][n] = new_busy[n];
        eb[m*DEPTH+n] = new_busy[n];
      end
    end
    exp_d_q.push_back(ed);
    exp_v_q.push_back(ev);
    exp_b_q.push_back(eb);
  endtask

  // driver: inputs change 1ns after the falling edge, expected outcome of the next rising edge is queued
  task automatic drive(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic bs, input logic [AW-1:0] ba,
                       input logic [NR-1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    @(negedge clk);
    #1;
    we0 = e0; waddr0 = a0; wdata0 = d0;
    we1 = e1; waddr1 = a1; wdata1 = d1;
    busy_set = bs; busy_addr = ba;
    rd_en = re; rd_addr = {ra1, ra0};
    model_step();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  function automatic logic [AW-1:0] r_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH-1));
  endfunction

  // scoreboard monitor: outputs of each rising edge are compared at the following falling edge
  initial begin
    logic [2*NR*DW-1:0] ed, ad;
    logic [2*NR-1:0] ev, av;
    logic [2*DEPTH-1:0] eb, ab;
    forever begin
      @(negedge clk);
      if (exp_d_q.size() > 0) begin
        ed = exp_d_q.pop_front();
        ev = exp_v_q.pop_front();
        eb = exp_b_q.pop_front();
        ad = {rd_data_z, rd_data_a};
        av = {rd_valid_z, rd_valid_a};
        ab = {busy_vec_z, busy_vec_a};
        for (int m = 0; m < 2; m++) begin
          for (int i = 0; i < NR; i++) begin
            chk($sformatf("rd_data inst%0d port%0d", m, i),
                64'(ad[(m*NR+i)*DW +: DW]), 64'(ed[(m*NR+i)*DW +: DW]));
            chk($sformatf("rd_valid inst%0d port%0d", m, i), 64'(av[m*NR+i]), 64'(ev[m*NR+i]));
          end
          chk($sformatf("busy_vec inst%0d", m), 64'(ab[m*DEPTH +: DEPTH]), 64'(eb[m*DEPTH +: DEPTH]));
        end
      end
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " rd_data a"}, 64'(rd_data_a), 64'd0);
    chk({tag, " rd_data z"}, 64'(rd_data_z), 64'd0);
    chk({tag, " rd_valid"}, 64'({rd_valid_z, rd_valid_a}), 64'd0);
    chk({tag, " busy_vec"}, 64'({busy_vec_z, busy_vec_a}), 64'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    #1;
    reset = 1'b0;

    // every register reads zero and valid out of reset
    for (int a = 0; a < DEPTH; a++) drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, AW'(a), AW'(a));
    // simultaneous writes to one register: port 1 wins
    drive(1, 3, 16'h1111, 1, 3, 16'h2222, 0, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3, 3);
    // pending register reads invalid until written
    drive(0, 0, 0, 0, 0, 0, 1, 5, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0);
    drive(1, 5, 16'hBEEF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 5, 5);
    // write during read of a pending register
    drive(1, 7, 16'h0001, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 7, 2'b00, 0, 0);
    drive(0, 0, 0, 1, 7, 16'hABCD, 0, 0, 2'b11, 7, 7);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 7, 7);
    // register 0 behaviour with and without hardwired zero
    drive(1, 0, 16'hFFFF, 0, 0, 0, 1, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0);
    // set beats the clear of a concurrent write, including a concurrent read
    drive(1, 2, 16'h7777, 0, 0, 0, 1, 2, 2'b01, 2, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2, 2);

    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), r_addr(), DW'($urandom),
            1'($urandom_range(0, 1)), r_addr(), DW'($urandom),
            1'($urandom_range(0, 3) == 0), r_addr(),
            NR'($urandom_range(0, 3)), r_addr(), r_addr());
    end

    // reset arriving mid-cycle discards the pending write and clears state at once
    drive(1, 9, 16'h5A5A, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0);
    @(negedge clk);
    #1;
    we0 = 1'b1; waddr0 = 4'd9; wdata0 = 16'h1234;
    busy_set = 1'b1; busy_addr = 4'd9;
    rd_en = 2'b11; rd_addr = {4'd9, 4'd9};
    #2;
    reset = 1'b1;
    #1;
    chk_outputs_zero("async reset");
    model_reset();
    @(negedge clk);
    chk_outputs_zero("reset held");
    #1;
    we0 = 1'b0; busy_set = 1'b0; rd_en = '0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 9, 9);
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard drained", 64'(exp_d_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
